// File: rtl/iodma_if.sv
// Register-bus and master-port signals of the IODMA block.
// The slave modport is the DMA engine's view; the master modport is the
// view of the surrounding system (CPU register bus plus IOPMP-side memory).
interface iodma_if;
    // Peripheral register bus
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    // DMA master port toward the IOPMP core-side input
    logic [31:0] dma_addr_o;
    logic [31:0] dma_data_i;
    logic [31:0] dma_data_o;
    logic        dma_req_o;
    logic        dma_we_o;

    // Completion interrupt
    logic        irq_o;

    modport slave (
        input  we_i, addr_i, data_i, dma_data_i,
        output data_o, dma_addr_o, dma_data_o, dma_req_o, dma_we_o, irq_o
    );

    modport master (
        output we_i, addr_i, data_i, dma_data_i,
        input  data_o, dma_addr_o, dma_data_o, dma_req_o, dma_we_o, irq_o
    );
endinterface

// File: rtl/iodma.sv
// IODMA: single-channel word copy engine.
// Software programs SRC, DST and LEN, then sets CTRL.start; the engine
// alternates one read (RD) and one write (WR) per word and finishes with a
// one-cycle FIN state that sets done and optionally pulses irq_o.
module iodma (
    input  logic   clk,
    input  logic   rst,
    iodma_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [3:0] ADDR_SRC  = 4'h0;
    localparam logic [3:0] ADDR_DST  = 4'h4;
    localparam logic [3:0] ADDR_LEN  = 4'h8;
    localparam logic [3:0] ADDR_CTRL = 4'hC;

    state_t      state, state_nx;
    logic [31:0] src, dst, data_buf;
    logic [15:0] len, idx, idx_inc;
    logic        irq_en, done, aborted;
    logic        busy, ctrl_wr, start, done_clr, abort;

    logic [31:0] dma_addr, dma_wdata;
    logic        dma_req, dma_we, irq;

    // Only the low nibble of the address is decoded.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^bus.addr_i[31:4];

    assign busy     = (state != IDLE);
    assign ctrl_wr  = bus.we_i && (bus.addr_i[3:0] == ADDR_CTRL);
    assign start    = ctrl_wr && bus.data_i[0];
    assign done_clr = ctrl_wr && bus.data_i[2];
    assign abort    = ctrl_wr && bus.data_i[3];
    assign idx_inc  = idx + 16'd1;

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_nx;
        end
    end

    // Next-state decode and master-port drive from the current state.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a value
        // unassigned and no latch is inferred.
        state_nx  = state;
        dma_req   = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = 32'h0;
        dma_wdata = 32'h0;
        irq       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (len == 16'd0) ? FIN : RD;
                end
            end
            RD: begin
                dma_req  = 1'b1;
                dma_addr = src + {14'b0, idx, 2'b00};
                state_nx = abort ? IDLE : WR;
            end
            WR: begin
                dma_req   = 1'b1;
                dma_we    = 1'b1;
                dma_addr  = dst + {14'b0, idx, 2'b00};
                dma_wdata = data_buf;
                if (abort) begin
                    state_nx = IDLE;
                end else if (idx_inc == len) begin
                    state_nx = FIN;
                end else begin
                    state_nx = RD;
                end
            end
            FIN: begin
                irq      = irq_en;
                state_nx = IDLE;
            end
        endcase
    end

    // Programming registers, transfer index, data buffer and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src      <= 32'h0;
            dst      <= 32'h0;
            len      <= 16'h0;
            idx      <= 16'h0;
            data_buf <= 32'h0;
            irq_en   <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            if (bus.we_i && !busy) begin
                case (bus.addr_i[3:0])
                    ADDR_SRC: src <= bus.data_i;
                    ADDR_DST: dst <= bus.data_i;
                    ADDR_LEN: len <= bus.data_i[15:0];
                    default:  ;
                endcase
            end
            if (ctrl_wr) begin
                irq_en <= bus.data_i[1];
            end
            if (done_clr) begin
                done <= 1'b0;
            end
            if (state == IDLE && start && len != 16'd0) begin
                idx     <= 16'd0;
                done    <= 1'b0;
                aborted <= 1'b0;
            end
            if (state == RD) begin
                data_buf <= bus.dma_data_i;
            end
            if (state == WR) begin
                idx <= idx_inc;
            end
            if ((state == RD || state == WR) && abort) begin
                aborted <= 1'b1;
            end
            // Placed last so a FIN set wins over a same-cycle done-clear.
            if (state == FIN) begin
                done <= 1'b1;
            end
        end
    end

    // Register read mux; unmapped offsets read as zero.
    always_comb begin
        bus.data_o = 32'h0;
        case (bus.addr_i[3:0])
            ADDR_SRC:  bus.data_o = src;
            ADDR_DST:  bus.data_o = dst;
            ADDR_LEN:  bus.data_o = {16'h0, len};
            ADDR_CTRL: bus.data_o = {28'h0, aborted, done, busy, irq_en};
            default:   bus.data_o = 32'h0;
        endcase
    end

    assign bus.dma_req_o  = dma_req;
    assign bus.dma_we_o   = dma_we;
    assign bus.dma_addr_o = dma_addr;
    assign bus.dma_data_o = dma_wdata;
    assign bus.irq_o      = irq;

endmodule

// File: tb/tb_iodma.sv
// Directed bench for iodma. Each test pushes the bus transactions and
// interrupts it expects into a scoreboard queue; a monitor on the falling
// clock edge pops and compares whenever the DUT requests or interrupts.
// Read data returned by the memory model is addr ^ 32'hDEADBEEF.
module tb_iodma;

    typedef struct packed {
        logic        irq;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic    clk;
    logic    rst;
    iodma_if bus ();

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    iodma dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data valid only while a read is requested.
    assign bus.dma_data_i = (bus.dma_req_o && !bus.dma_we_o) ?
                            (bus.dma_addr_o ^ 32'hDEADBEEF) : 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic push_rd(input logic [31:0] a);
        exp_q.push_back('{irq: 1'b0, we: 1'b0, addr: a, data: 32'h0});
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{irq: 1'b0, we: 1'b1, addr: a, data: d});
    endtask

    task automatic push_irq();
        exp_q.push_back('{irq: 1'b1, we: 1'b0, addr: 32'h0, data: 32'h0});
    endtask

    // One register write; called and returns one time unit after a rising edge.
    task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
        bus.we_i   = 1'b1;
        bus.addr_i = a;
        bus.data_i = d;
        @(posedge clk);
        #1;
        bus.we_i   = 1'b0;
        bus.data_i = 32'h0;
    endtask

    // Combinational read without consuming a clock cycle.
    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.addr_i = a;
        #1;
        check(name, bus.data_o, exp);
    endtask

    // Read, then realign to one time unit after the next rising edge.
    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        peek(name, a, exp);
        @(posedge clk);
        #1;
    endtask

    // Poll STATUS.busy with a cycle budget; an expired budget is a failure.
    task automatic wait_idle(input int budget);
        int n = 0;
        bus.addr_i = 32'hC;
        #1;
        while (bus.data_o[1] && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idle_timeout", {31'h0, bus.data_o[1]}, 32'h0);
    endtask

    // Scoreboard monitor: compare every request/interrupt, and require
    // quiet master-port outputs otherwise.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.dma_req_o || bus.irq_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {30'h0, bus.irq_o, bus.dma_req_o}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("event_kind", {30'h0, bus.irq_o, bus.dma_req_o},
                          e.irq ? 32'd2 : 32'd1);
                    if (!e.irq) begin
                        check("dma_we", {31'h0, bus.dma_we_o}, {31'h0, e.we});
                        check("dma_addr", bus.dma_addr_o, e.addr);
                        check("dma_wdata", bus.dma_data_o, e.data);
                    end
                end
            end else begin
                check("idle_outputs",
                      {29'h0, bus.dma_we_o, |bus.dma_addr_o, |bus.dma_data_o}, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        bus.we_i   = 1'b0;
        bus.addr_i = 32'h0;
        bus.data_i = 32'h0;

        // Reset state
        #1;
        check("reset_outputs",
              {27'h0, bus.dma_req_o, bus.dma_we_o, |bus.dma_addr_o, |bus.dma_data_o, bus.irq_o},
              32'h0);
        peek("reset_src", 32'h0, 32'h0);
        peek("reset_len", 32'h8, 32'h0);
        peek("reset_status", 32'hC, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Register access, LEN truncation, unmapped offsets
        reg_write(32'h0, 32'h11111110);
        rd_check("src_readback", 32'h0, 32'h11111110);
        reg_write(32'h2, 32'hFFFFFFFF);
        rd_check("unmapped_read", 32'h2, 32'h0);
        rd_check("unmapped_no_side_effect_src", 32'h0, 32'h11111110);
        rd_check("unmapped_no_side_effect_len", 32'h8, 32'h0);
        reg_write(32'h8, 32'h00012345);
        rd_check("len_16bit", 32'h8, 32'h00002345);

        // Three-word copy with interrupt
        reg_write(32'h0, 32'h20000000);
        reg_write(32'h4, 32'h30000000);
        reg_write(32'h8, 32'd3);
        push_rd(32'h20000000);
        push_wr(32'h30000000, 32'hFEADBEEF);
        push_rd(32'h20000004);
        push_wr(32'h30000004, 32'hFEADBEEB);
        push_rd(32'h20000008);
        push_wr(32'h30000008, 32'hFEADBEE7);
        push_irq();
        reg_write(32'hC, 32'h3);
        wait_idle(20);
        rd_check("copy3_status", 32'hC, 32'h5);
        rd_check("copy3_dst_readback", 32'h4, 32'h30000000);

        // LEN=0 without interrupt: straight to FIN, no bus activity
        reg_write(32'h8, 32'h0);
        reg_write(32'hC, 32'h4);
        rd_check("len0_done_cleared", 32'hC, 32'h0);
        reg_write(32'hC, 32'h1);
        peek("len0_in_fin", 32'hC, 32'h2);
        @(posedge clk);
        #1;
        rd_check("len0_done_after_fin", 32'hC, 32'h4);

        // LEN=0 with interrupt; done-clear during FIN loses to the set
        reg_write(32'hC, 32'h4);
        push_irq();
        reg_write(32'hC, 32'h3);
        peek("len0_irq_in_fin", 32'hC, 32'h3);
        reg_write(32'hC, 32'h4);
        rd_check("fin_set_beats_clear", 32'hC, 32'h4);
        reg_write(32'hC, 32'h4);
        rd_check("done_clear_idle", 32'hC, 32'h0);

        // Source address wraps past the top of the address space
        reg_write(32'h0, 32'hFFFFFFFC);
        reg_write(32'h4, 32'h00000040);
        reg_write(32'h8, 32'd2);
        push_rd(32'hFFFFFFFC);
        push_wr(32'h00000040, 32'h21524113);
        push_rd(32'h00000000);
        push_wr(32'h00000044, 32'hDEADBEEF);
        reg_write(32'hC, 32'h1);
        wait_idle(20);
        rd_check("wrap_status", 32'hC, 32'h4);

        // Register writes and restart while busy are ignored
        reg_write(32'h0, 32'h00000100);
        reg_write(32'h4, 32'h00000200);
        reg_write(32'h8, 32'd2);
        push_rd(32'h00000100);
        push_wr(32'h00000200, 32'hDEADBFEF);
        push_rd(32'h00000104);
        push_wr(32'h00000204, 32'hDEADBFEB);
        push_irq();
        reg_write(32'hC, 32'h3);
        reg_write(32'h8, 32'd9);
        reg_write(32'h0, 32'h00000500);
        reg_write(32'hC, 32'h3);
        wait_idle(20);
        rd_check("busy_len_kept", 32'h8, 32'd2);
        rd_check("busy_src_kept", 32'h0, 32'h00000100);
        rd_check("busy_status", 32'hC, 32'h5);

        // Abort during the second read
        reg_write(32'h0, 32'h00001000);
        reg_write(32'h4, 32'h00002000);
        reg_write(32'h8, 32'd4);
        push_rd(32'h00001000);
        push_wr(32'h00002000, 32'hDEADAEEF);
        push_rd(32'h00001004);
        reg_write(32'hC, 32'h3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reg_write(32'hC, 32'hA);
        peek("abort_next_cycle_idle", 32'hC, 32'h9);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rd_check("abort_status", 32'hC, 32'h9);
        check("abort_queue_drained", exp_q.size(), 32'd0);

        // Asynchronous reset in the middle of a write
        reg_write(32'h0, 32'h00003000);
        reg_write(32'h4, 32'h00004000);
        reg_write(32'h8, 32'd2);
        push_rd(32'h00003000);
        reg_write(32'hC, 32'h3);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_wr_outputs",
              {27'h0, bus.dma_req_o, bus.dma_we_o, |bus.dma_addr_o, |bus.dma_data_o, bus.irq_o},
              32'h0);
        peek("rst_src", 32'h0, 32'h0);
        peek("rst_dst", 32'h4, 32'h0);
        peek("rst_len", 32'h8, 32'h0);
        peek("rst_status", 32'hC, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rd_check("post_rst_status", 32'hC, 32'h0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iodma.md
IODMA -- requirements
Module: iodma

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; state clears on negedge rst, independent of clk.
REQ-003 we_i  input  1  register write strobe from the peripheral bus.
REQ-004 addr_i  input  32  register address; only addr_i[3:0] decoded.
REQ-005 data_i  input  32  register write data.
REQ-006 data_o  output  32  register read data, combinational from addr_i[3:0].
REQ-007 dma_addr_o  output  32  master-port byte address, toward the IOPMP core-side input.
REQ-008 dma_data_i  input  32  master-port read data, valid in the same cycle as a read request.
REQ-009 dma_data_o  output  32  master-port write data.
REQ-010 dma_req_o  output  1  master-port request.
REQ-011 dma_we_o  output  1  master-port write enable: 1 = write, 0 = read.
REQ-012 irq_o  output  1  completion interrupt, one-cycle pulse.

Function
REQ-013 Register map SHALL be: 0x0 SRC, 0x4 DST, 0x8 LEN (word count, 16 bits used), 0xC CTRL/STATUS.
REQ-014 CTRL write fields SHALL be: bit0 start, bit1 irq_en (stored), bit2 done-clear (write 1), bit3 abort (write 1).
REQ-015 STATUS read value SHALL be {28'b0, aborted, done, busy, irq_en}.
REQ-016 Unmapped addresses SHALL read 0 and ignore writes.
REQ-017 FSM states SHALL be IDLE, RD, WR, FIN; busy = (state != IDLE).
REQ-018 Writes to SRC, DST and LEN SHALL be ignored while busy.
REQ-019 IDLE + start, LEN != 0: SHALL clear idx, done and aborted, then go to RD.
REQ-020 IDLE + start, LEN == 0: SHALL go to FIN without any bus request.
REQ-021 RD: SHALL drive dma_req_o=1, dma_we_o=0, dma_addr_o=SRC+4*idx, latch dma_data_i into buf at the clock edge, then go to WR.
REQ-022 WR: SHALL drive dma_req_o=1, dma_we_o=1, dma_addr_o=DST+4*idx, dma_data_o=buf, then increment idx.
REQ-023 From WR, the FSM SHALL go to FIN if idx+1 == LEN, otherwise to RD.
REQ-024 Each word SHALL take exactly 2 cycles; an N-word transfer SHALL take 2N+1 cycles from start to FIN exit.
REQ-025 FIN: SHALL set done, pulse irq_o for 1 cycle if irq_en, then go to IDLE.
REQ-026 Address arithmetic SHALL be 32-bit modulo 2^32; wrap past 0xFFFFFFFC continues at 0x0.
REQ-027 Abort in RD or WR SHALL go to IDLE on the next edge, set aborted, leave done clear and raise no irq; the in-flight request is still driven that cycle.
REQ-028 Start or abort while busy: start SHALL be ignored; abort in IDLE or FIN SHALL be ignored.
REQ-029 Done-clear and a FIN set in the same cycle: set SHALL win.
REQ-030 Outside RD/WR, dma_req_o, dma_we_o, dma_addr_o and dma_data_o SHALL be 0.
REQ-031 The block SHALL have no handling of IOPMP denial; a denied request completes with whatever data returns.

Reset
REQ-032 On reset: state=IDLE; SRC, DST, LEN, idx and buf = 0; irq_en, done and aborted = 0.
REQ-033 On reset: all dma_* outputs = 0 and irq_o = 0.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer immediately with no further requests and no irq.

Verification
REQ-035 SRC=0x20000000, DST=0x30000000, LEN=3, CTRL=0x3 -> 3 read/write pairs (RD@0x20000000, WR@0x30000000, then +4, +8); irq_o pulses once; STATUS=0x5 after.
REQ-036 LEN=0, start -> dma_req_o stays 0; done=1 one cycle after FIN; irq pulse only if irq_en.
REQ-037 SRC=0xFFFFFFFC, LEN=2 -> read addresses 0xFFFFFFFC then 0x00000000.
REQ-038 LEN=4, abort written during the 2nd RD -> next cycle IDLE; STATUS aborted=1, done=0; no irq; writes seen only to DST+0.
REQ-039 Write LEN=9 while busy, and restart while busy -> both ignored; transfer completes with the original LEN.
REQ-040 rst low mid-WR -> all outputs 0 immediately (asynchronously); registers at reset values.
